// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester logic_unit arbiter:
// op encodings understood by logic_unit and the arbiter FSM states.
package logic_unit_arbiter_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_INV  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Purely combinational bitwise logic unit shared by both requesters.
// OP_NOT only uses operand a; the unsupported encoding yields zero.
module logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            op,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two requesters,
// one transaction in flight, with a registered tagged response channel.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [2:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [2:0]            req1_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_id,
    output logic                  rsp_err
);

    arb_state_e            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic                  id_q, id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  grant0, grant1;
    logic [DATA_WIDTH-1:0] lu_result;

    logic_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_logic (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (lu_result)
    );

    // On a tie the requester that was not served last wins; last_grant_q=1 favours req0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_IDLE) begin
            grant0 = req0_valid & (~req1_valid |  last_grant_q);
            grant1 = req1_valid & (~req0_valid | ~last_grant_q);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (grant0) begin
                    a_d          = req0_a;
                    b_d          = req0_b;
                    op_d         = req0_op;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = S_EXEC;
                end else if (grant1) begin
                    a_d          = req1_a;
                    b_d          = req1_b;
                    op_d         = req1_op;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = lu_result;
                rsp_err_d   = (op_q == OP_INV);
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // The response tag is the captured requester id, which only changes on acceptance.
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = id_q;
    assign rsp_err   = rsp_err_q;

endmodule
